// File: rtl/pe_pkg.sv
// Shared constants, FSM state type and index-to-one-hot helper for the
// pe_req_arbiter slice.
package pe_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [N_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/pe_prio_enc8.sv
// Combinational 8-to-3 priority encoder, bit 7 highest. gs_o flags a hit,
// eno_o flags "enabled but nothing requested".
module pe_prio_enc8
  import pe_pkg::*;
(
  input  logic [N_REQ-1:0] in_i,
  input  logic             en_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             gs_o,
  output logic             eno_o
);

  always_comb begin
    idx_o = '0;
    gs_o  = 1'b0;
    eno_o = 1'b0;
    if (en_i) begin
      if (in_i == '0) begin
        eno_o = 1'b1;
      end else begin
        gs_o = 1'b1;
        // Ascending scan: the last hit, i.e. the highest set bit, wins.
        for (int i = 0; i < N_REQ; i++) begin
          if (in_i[i]) idx_o = IDX_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/pe_req_arbiter.sv
// Eight-way latched-grant arbiter: fixed or round-robin selection, masking,
// release handshake and a hold-timeout watchdog. All outputs are registered.
module pe_req_arbiter
  import pe_pkg::*;
#(
  parameter int HOLD_MAX = 255,
  parameter int CNT_W    = 8
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_ni,
  input  logic             en_i,
  input  logic             mode_rr_i,
  input  logic [N_REQ-1:0] mask_i,
  input  logic [N_REQ-1:0] req_i,
  input  logic             done_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0] gnt_idx_o,
  output logic             gnt_valid_o,
  output logic             idle_o,
  output logic             timeout_o
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic             vld_q, vld_d;
  logic             idle_q, idle_d;
  logic             tmo_q, tmo_d;

  logic [N_REQ-1:0] elig;
  logic [N_REQ-1:0] rot_rev;
  logic [N_REQ-1:0] enc_in;
  logic [IDX_W-1:0] enc_idx;
  logic             enc_gs;
  logic             enc_eno;
  logic [IDX_W-1:0] win_idx;
  logic             at_max;
  logic             release_c;

  assign elig = req_i & ~mask_i;

  // Round-robin: rotate right by the pointer and bit-reverse, so the
  // highest-first encoder returns the lowest set bit of the rotated vector.
  always_comb begin
    rot_rev = '0;
    for (int i = 0; i < N_REQ; i++) begin
      rot_rev[N_REQ-1-i] = elig[IDX_W'(i) + ptr_q];
    end
  end

  assign enc_in  = mode_rr_i ? rot_rev : elig;
  assign win_idx = mode_rr_i ? (~enc_idx + ptr_q) : enc_idx;

  pe_prio_enc8 u_enc (
    .in_i  (enc_in),
    .en_i  (en_i),
    .idx_o (enc_idx),
    .gs_o  (enc_gs),
    .eno_o (enc_eno)
  );

  assign at_max    = (cnt_q == CNT_W'(HOLD_MAX - 1));
  assign release_c = done_i | ~req_i[idx_q] | at_max;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    vld_d   = vld_q;
    tmo_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enc_gs) begin
          state_d = ST_GRANT;
          idx_d   = win_idx;
          gnt_d   = onehot(win_idx);
          vld_d   = 1'b1;
          cnt_d   = '0;
        end
      end
      ST_GRANT: begin
        if (release_c) begin
          state_d = ST_IDLE;
          idx_d   = '0;
          gnt_d   = '0;
          vld_d   = 1'b0;
          cnt_d   = '0;
          // An owner release that coincides with the limit is not a timeout.
          tmo_d   = at_max & ~done_i;
          if (mode_rr_i) ptr_d = idx_q + IDX_W'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    idle_d = (state_d == ST_IDLE) & ~enc_gs;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      vld_q   <= 1'b0;
      idle_q  <= 1'b1;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      vld_q   <= vld_d;
      idle_q  <= idle_d;
      tmo_q   <= tmo_d;
    end
  end

  assign gnt_o       = gnt_q;
  assign gnt_idx_o   = idx_q;
  assign gnt_valid_o = vld_q;
  assign idle_o      = idle_q;
  assign timeout_o   = tmo_q;

endmodule

// File: tb/tb_pe_req_arbiter.sv
// Scoreboard bench for pe_req_arbiter: stimulus queues expected grants
// (index, hold length, timeout flag); a negedge monitor checks them.
module tb_pe_req_arbiter;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       mode_rr;
  logic [7:0] mask;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       idle;
  logic       tmo;

  typedef struct {
    logic [2:0] idx;
    int         len;
    logic       tmo;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_mis = 0;

  pe_req_arbiter #(.HOLD_MAX(4), .CNT_W(8)) dut (
    .wb_clk_i    (clk),
    .wb_rst_ni   (rst_n),
    .en_i        (en),
    .mode_rr_i   (mode_rr),
    .mask_i      (mask),
    .req_i       (req),
    .done_i      (done),
    .gnt_o       (gnt),
    .gnt_idx_o   (gnt_idx),
    .gnt_valid_o (gnt_valid),
    .idle_o      (idle),
    .timeout_o   (tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] idx, input int len, input logic t);
    exp_t e;
    e.idx = idx;
    e.len = len;
    e.tmo = t;
    exp_q.push_back(e);
  endtask

  // Called on the first visible grant cycle; releases after L grant cycles.
  task automatic hold_done(input int L);
    repeat (L - 1) step();
    done = 1'b1;
    step();
    done = 1'b0;
  endtask

  // Monitor: compares every grant against the scoreboard.
  initial begin
    bit   in_g;
    int   len;
    exp_t cur;
    in_g = 1'b0;
    len  = 0;
    cur.idx = '0;
    cur.len = 0;
    cur.tmo = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_g = 1'b0;
        len  = 0;
      end else if (gnt_valid) begin
        if (!in_g) begin
          in_g = 1'b1;
          len  = 0;
          if (exp_q.size() == 0) begin
            n_vec++;
            n_mis++;
            $display("FAIL unexpected_grant: got idx %0d with nothing queued at %0t", gnt_idx, $time);
            cur.idx = '0;
            cur.len = 0;
            cur.tmo = 1'b0;
          end else begin
            cur = exp_q.pop_front();
          end
          check("grant_idx", 32'(gnt_idx), 32'(cur.idx));
        end
        len++;
        check("gnt_onehot", 32'(gnt), 32'(8'd1 << cur.idx));
      end else begin
        check("gnt_clear", {21'd0, gnt_idx, gnt}, 32'd0);
        if (in_g) begin
          in_g = 1'b0;
          check("hold_len", 32'(len), 32'(cur.len));
          check("timeout_at_release", 32'(tmo), 32'(cur.tmo));
        end else begin
          check("spurious_timeout", 32'(tmo), 32'd0);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    en      = 1'b0;
    mode_rr = 1'b0;
    mask    = 8'h00;
    req     = 8'h00;
    done    = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_valid", 32'(gnt_valid), 32'd0);
    check("rst_idle", 32'(idle), 32'd1);
    check("rst_timeout", 32'(tmo), 32'd0);
    rst_n = 1'b1;

    // Fixed priority: highest eligible bit of 0010_0101 is 5
    en  = 1'b1;
    req = 8'b0010_0101;
    push(3'd5, 3, 1'b0);
    push(3'd5, 2, 1'b0);
    step();
    hold_done(3);
    check("gap_valid", 32'(gnt_valid), 32'd0);
    check("gap_idle_pending", 32'(idle), 32'd0);
    step();
    hold_done(2);
    req = 8'h00;
    step();

    // Round-robin fairness: 0..7 then 0, one idle cycle between grants
    mode_rr = 1'b1;
    req     = 8'hFF;
    for (int i = 0; i < 9; i++) push(3'(i % 8), 2, 1'b0);
    for (int i = 0; i < 9; i++) begin
      step();
      hold_done(2);
    end
    req = 8'h00;
    step();

    // Masking and enable
    mode_rr = 1'b0;
    mask    = 8'h80;
    req     = 8'h81;
    push(3'd0, 2, 1'b0);
    step();
    en = 1'b0;
    hold_done(2);
    check("en_off_valid", 32'(gnt_valid), 32'd0);
    check("en_off_idle", 32'(idle), 32'd1);
    step();
    check("en_off_no_regrant", 32'(gnt_valid), 32'd0);
    req  = 8'h00;
    mask = 8'h00;
    en   = 1'b1;
    step();

    // Timeout after 4 held cycles, then re-grant
    req = 8'h08;
    push(3'd3, 4, 1'b1);
    push(3'd3, 2, 1'b0);
    step();
    repeat (4) step();
    check("timeout_pulse", 32'(tmo), 32'd1);
    check("timeout_valid", 32'(gnt_valid), 32'd0);
    step();
    check("timeout_single", 32'(tmo), 32'd0);
    hold_done(2);
    req = 8'h00;
    step();

    // Request drop releases without timeout
    req = 8'h20;
    push(3'd5, 2, 1'b0);
    step();
    step();
    req = 8'h00;
    step();
    check("drop_no_timeout", 32'(tmo), 32'd0);
    step();

    // done_i together with the timeout condition
    req = 8'h20;
    push(3'd5, 4, 1'b0);
    step();
    hold_done(4);
    req = 8'h00;
    check("done_at_max_no_timeout", 32'(tmo), 32'd0);
    step();

    // Async reset mid-grant, then pointer restarts at 0
    mode_rr = 1'b1;
    req     = 8'h40;
    push(3'd6, 0, 1'b0);
    step();
    @(negedge clk);
    #1;
    check("pre_reset_idx", 32'(gnt_idx), 32'd6);
    rst_n = 1'b0;
    #1;
    check("async_rst_gnt", 32'(gnt), 32'd0);
    check("async_rst_valid", 32'(gnt_valid), 32'd0);
    check("async_rst_idle", 32'(idle), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    req   = 8'h41;
    rst_n = 1'b1;
    push(3'd0, 1, 1'b0);
    step();
    hold_done(1);
    req = 8'h00;
    repeat (3) step();
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
